// File: rtl/mem_responder.sv
// Purpose: word-organised memory responder for the core's unified port, with side-band preload.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the edge that accepts a request.
// Backpressure: the core holds memread/memwrite until ready; dropping both while waiting aborts.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   adr, memread, memwrite  byte address and request strobes from the core
//   wdata                   write data, held alongside memwrite
//   rdata, ready, err       response word, one-cycle response pulse, error flag
//   init_we/addr/data       preload port, honoured only while idle
//   busy, state_o           activity flag and FSM state (0 idle, 1 wait, 2 resp)
module mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       adr,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              err,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [31:0]       init_data,
   output logic              busy,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_adr;
   logic [31:0] r_wdata;
   logic        r_rd;
   logic        r_wr;
   logic [31:0] r_rdata;
   logic        r_ready;
   logic        r_err;
   logic [31:0] r_mem [DEPTH];

   // The response is formed on the edge that enters RESP. With zero wait
   // states that edge is the accepting edge, so the live request is used;
   // otherwise the request latched at acceptance is used.
   logic              w_in_idle;
   logic [31:0]       w_req_adr;
   logic              w_req_rd;
   logic              w_req_wr;
   logic              w_bad;
   logic [ADDR_W-1:0] w_idx;
   logic [31:0]       w_rword;
   logic [31:0]       w_resp_dat;
   logic [ADDR_W-1:0] w_wr_idx;

   assign w_in_idle  = (r_state == S_IDLE);
   assign w_req_adr  = w_in_idle ? adr      : r_adr;
   assign w_req_rd   = w_in_idle ? memread  : r_rd;
   assign w_req_wr   = w_in_idle ? memwrite : r_wr;
   assign w_bad      = (w_req_adr[1:0] != 2'b00) | (w_req_adr >= LIMIT) | (w_req_rd & w_req_wr);
   assign w_idx      = w_req_adr[ADDR_W+1:2];
   assign w_rword    = r_mem[w_idx];
   assign w_resp_dat = (w_req_rd & ~w_bad) ? w_rword : 32'd0;
   assign w_wr_idx   = r_adr[ADDR_W+1:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_adr   <= 32'd0;
         r_wdata <= 32'd0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_rdata <= 32'd0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rdata <= 32'd0;
               r_ready <= 1'b0;
               r_err   <= 1'b0;
               // Preload owns the idle cycle; a pending request is taken later.
               if (!init_we && (memread || memwrite)) begin
                  r_adr   <= adr;
                  r_wdata <= wdata;
                  r_rd    <= memread;
                  r_wr    <= memwrite;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= S_RESP;
                     r_ready <= 1'b1;
                     r_err   <= w_bad;
                     r_rdata <= w_resp_dat;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= 4'(WAIT_CYCLES);
                  end
               end
            end
            S_WAIT: begin
               if (!memread && !memwrite) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end else if (r_cnt == 4'd1) begin
                  r_state <= S_RESP;
                  r_cnt   <= 4'd0;
                  r_ready <= 1'b1;
                  r_err   <= w_bad;
                  r_rdata <= w_resp_dat;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_rdata <= 32'd0;
               r_ready <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Storage has no reset so a preloaded program survives a reset pulse.
   // The write commits on the edge leaving RESP, only for an error-free write.
   always_ff @(posedge clk) begin
      if (r_state == S_RESP && r_wr && !r_err) begin
         r_mem[w_wr_idx] <= r_wdata;
      end else if (r_state == S_IDLE && init_we) begin
         r_mem[init_addr] <= init_data;
      end
   end

   assign rdata   = r_rdata;
   assign ready   = r_ready;
   assign err     = r_err;
   assign busy    = (r_state == S_WAIT) || (r_state == S_RESP);
   assign state_o = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 uses two wait states, instance 1 uses none.
module tb_mem_responder;

   logic        clk;
   logic        reset;
   logic [31:0] adr_v       [2];
   logic        memread_v   [2];
   logic        memwrite_v  [2];
   logic [31:0] wdata_v     [2];
   logic [31:0] rdata_v     [2];
   logic        ready_v     [2];
   logic        err_v       [2];
   logic        init_we_v   [2];
   logic [7:0]  init_addr_v [2];
   logic [31:0] init_data_v [2];
   logic        busy_v      [2];
   logic [1:0]  state_o_v   [2];

   int vectors     = 0;
   int miscompares = 0;

   mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset),
      .adr(adr_v[0]), .memread(memread_v[0]), .memwrite(memwrite_v[0]), .wdata(wdata_v[0]),
      .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]),
      .init_we(init_we_v[0]), .init_addr(init_addr_v[0]), .init_data(init_data_v[0]),
      .busy(busy_v[0]), .state_o(state_o_v[0])
   );

   mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .reset(reset),
      .adr(adr_v[1]), .memread(memread_v[1]), .memwrite(memwrite_v[1]), .wdata(wdata_v[1]),
      .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]),
      .init_we(init_we_v[1]), .init_addr(init_addr_v[1]), .init_data(init_data_v[1]),
      .busy(busy_v[1]), .state_o(state_o_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int s, input logic [7:0] idx, input logic [31:0] d);
      @(negedge clk);
      init_we_v[s]   = 1'b1;
      init_addr_v[s] = idx;
      init_data_v[s] = d;
      @(negedge clk);
      init_we_v[s]   = 1'b0;
   endtask

   // Drives one request, waits (bounded) for ready, then drops the request.
   // lat counts falling edges after the accepting rising edge; -1 means no ready.
   task automatic access(input int s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdat,
                         output logic e, output logic [1:0] st1);
      @(negedge clk);
      memread_v[s]  = rd;
      memwrite_v[s] = wr;
      adr_v[s]      = a;
      wdata_v[s]    = d;
      lat  = -1;
      rdat = 32'd0;
      e    = 1'b0;
      st1  = 2'd3;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) st1 = state_o_v[s];
         if (ready_v[s]) begin
            lat  = n;
            rdat = rdata_v[s];
            e    = err_v[s];
            break;
         end
      end
      memread_v[s]  = 1'b0;
      memwrite_v[s] = 1'b0;
      @(negedge clk);
      check("ready_single_cycle", 32'(ready_v[s]), 32'd0);
   endtask

   task automatic xfer(input string tag, input int s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_dat, input logic exp_err);
      int          lat;
      logic [31:0] rdat;
      logic        e;
      logic [1:0]  st1;
      access(s, rd, wr, a, d, lat, rdat, e, st1);
      check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_rdata", tag), rdat, exp_dat);
      check($sformatf("%s_err", tag), 32'(e), 32'(exp_err));
   endtask

   initial begin
      int          lat;
      logic [31:0] rdat;
      logic        e;
      logic [1:0]  st1;
      logic        seen;

      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
         adr_v[s] = 32'd0;   memread_v[s] = 1'b0;  memwrite_v[s] = 1'b0;
         wdata_v[s] = 32'd0; init_we_v[s] = 1'b0;  init_addr_v[s] = 8'd0;
         init_data_v[s] = 32'd0;
      end
      @(negedge clk);
      @(negedge clk);
      check("reset_rdata", rdata_v[0], 32'd0);
      check("reset_ready", 32'(ready_v[0]), 32'd0);
      check("reset_err", 32'(err_v[0]), 32'd0);
      check("reset_busy", 32'(busy_v[0]), 32'd0);
      check("reset_state", 32'(state_o_v[0]), 32'd0);
      reset = 1'b0;

      // Preload program words.
      preload(0, 8'd0, 32'h11);
      preload(0, 8'd1, 32'h22);
      preload(0, 8'd2, 32'h33);
      preload(0, 8'd3, 32'h44);
      preload(0, 8'd255, 32'hABCD);

      // Read of preloaded word 2, with state observed one cycle after acceptance.
      access(0, 1'b1, 1'b0, 32'h8, 32'd0, lat, rdat, e, st1);
      check("rd8_latency", 32'(lat), 32'd3);
      check("rd8_rdata", rdat, 32'h33);
      check("rd8_err", 32'(e), 32'd0);
      check("rd8_wait_state", 32'(st1), 32'd1);

      // Write then read back; neighbouring word untouched.
      xfer("wr10", 0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'd0, 1'b0);
      xfer("rd10", 0, 1'b1, 1'b0, 32'h10, 32'd0, 3, 32'hDEADBEEF, 1'b0);
      xfer("rdC",  0, 1'b1, 1'b0, 32'hC,  32'd0, 3, 32'h44, 1'b0);

      // Misaligned read and write; word 1 must stay intact.
      xfer("rd6_misaligned", 0, 1'b1, 1'b0, 32'h6, 32'd0, 3, 32'd0, 1'b1);
      xfer("wr6_misaligned", 0, 1'b0, 1'b1, 32'h6, 32'h55555555, 3, 32'd0, 1'b1);
      xfer("rd4_after_misaligned", 0, 1'b1, 1'b0, 32'h4, 32'd0, 3, 32'h22, 1'b0);

      // Abort while waiting.
      @(negedge clk);
      memwrite_v[0] = 1'b1;
      adr_v[0]      = 32'h4;
      wdata_v[0]    = 32'hCAFE;
      @(negedge clk);
      check("abort_in_wait", 32'(state_o_v[0]), 32'd1);
      memwrite_v[0] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ready_v[0]) seen = 1'b1;
      end
      check("abort_no_ready", 32'(seen), 32'd0);
      check("abort_idle", 32'(state_o_v[0]), 32'd0);
      xfer("rd4_after_abort", 0, 1'b1, 1'b0, 32'h4, 32'd0, 3, 32'h22, 1'b0);

      // Reset asserted during WAIT.
      @(negedge clk);
      memread_v[0] = 1'b1;
      adr_v[0]     = 32'h0;
      @(negedge clk);
      check("pre_reset_busy", 32'(busy_v[0]), 32'd1);
      reset = 1'b1;
      #1;
      check("midreset_ready", 32'(ready_v[0]), 32'd0);
      check("midreset_state", 32'(state_o_v[0]), 32'd0);
      check("midreset_busy", 32'(busy_v[0]), 32'd0);
      memread_v[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      xfer("rd0_after_reset", 0, 1'b1, 1'b0, 32'h0, 32'd0, 3, 32'h11, 1'b0);
      xfer("rd10_after_reset", 0, 1'b1, 1'b0, 32'h10, 32'd0, 3, 32'hDEADBEEF, 1'b0);

      // Illegal and boundary requests.
      xfer("both_strobes", 0, 1'b1, 1'b1, 32'h0, 32'h99, 3, 32'd0, 1'b1);
      xfer("wr_out_of_range", 0, 1'b0, 1'b1, 32'h400, 32'h12345678, 3, 32'd0, 1'b1);
      xfer("rd_out_of_range", 0, 1'b1, 1'b0, 32'h400, 32'd0, 3, 32'd0, 1'b1);
      xfer("rd0_after_illegal", 0, 1'b1, 1'b0, 32'h0, 32'd0, 3, 32'h11, 1'b0);
      xfer("rd_last_word", 0, 1'b1, 1'b0, 32'h3FC, 32'd0, 3, 32'hABCD, 1'b0);

      // Zero-wait-state instance.
      preload(1, 8'd2, 32'h77);
      access(1, 1'b1, 1'b0, 32'h8, 32'd0, lat, rdat, e, st1);
      check("w0_rd8_latency", 32'(lat), 32'd1);
      check("w0_rd8_rdata", rdat, 32'h77);
      check("w0_rd8_state", 32'(st1), 32'd2);
      xfer("w0_wr20", 1, 1'b0, 1'b1, 32'h20, 32'h5A5A0001, 1, 32'd0, 1'b0);
      xfer("w0_rd20", 1, 1'b1, 1'b0, 32'h20, 32'd0, 1, 32'h5A5A0001, 1'b0);
      xfer("w0_misaligned", 1, 1'b1, 1'b0, 32'h6, 32'd0, 1, 32'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
